// File: rtl/trk_pkg.sv
// Shared types and constants for the B1 tracking-loop sequencer.
// Includes the state encoding, the bandwidth codes and a saturating absolute value.
package trk_pkg;

    localparam int ACC_W = 24;

    typedef enum logic [2:0] {
        TRK_IDLE   = 3'd0,
        TRK_WARM   = 3'd1,
        TRK_PULLIN = 3'd2,
        TRK_TRACK  = 3'd3,
        TRK_LOST   = 3'd4
    } trk_state_e;

    localparam logic [1:0] BW_IDLE   = 2'b00;
    localparam logic [1:0] BW_WIDE   = 2'b01;
    localparam logic [1:0] BW_NARROW = 2'b10;

    // -2^(ACC_W-1) has no positive counterpart, so it clamps to the largest positive value.
    function automatic logic [ACC_W-1:0] sat_abs(input logic [ACC_W-1:0] x);
        logic [ACC_W-1:0] res;
        if (!x[ACC_W-1]) begin
            res = x;
        end else if (x == {1'b1, {(ACC_W-1){1'b0}}}) begin
            res = {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            res = ~x + ACC_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/trk_lock_det.sv
// Prompt-power lock detector: per-epoch good/bad decision plus consecutive good/bad counters.
// The hit outputs flag the evaluation that brings a counter to its threshold.
module trk_lock_det
    import trk_pkg::*;
#(
    parameter logic [ACC_W-1:0] PWR_TH   = 24'd4096,
    parameter int               LOCK_CNT = 8,
    parameter int               LOSS_CNT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             eval,
    input  logic             clr,
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] acc_q,
    output logic             lock_hit,
    output logic             loss_hit
);

    localparam int MAX_CNT = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    logic [ACC_W-1:0] a_i;
    logic [ACC_W-1:0] a_q;
    logic             good;
    logic [CW-1:0]    good_cnt_q, good_cnt_d;
    logic [CW-1:0]    bad_cnt_q,  bad_cnt_d;

    always_comb begin
        a_i  = sat_abs(acc_i);
        a_q  = sat_abs(acc_q);
        // The 2*aQ term needs the extra bit, so the ratio test runs at ACC_W+1 bits.
        good = (a_i >= PWR_TH) && ({1'b0, a_i} >= {a_q, 1'b0});
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (!en || clr) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (eval) begin
            if (good) begin
                bad_cnt_d  = '0;
                good_cnt_d = (good_cnt_q >= CW'(LOCK_CNT)) ? good_cnt_q : good_cnt_q + CW'(1);
            end else begin
                good_cnt_d = '0;
                bad_cnt_d  = (bad_cnt_q >= CW'(LOSS_CNT)) ? bad_cnt_q : bad_cnt_q + CW'(1);
            end
        end
    end

    assign lock_hit = eval && good  && (good_cnt_q >= CW'(LOCK_CNT - 1));
    assign loss_hit = eval && !good && (bad_cnt_q  >= CW'(LOSS_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

endmodule

// File: rtl/trk_loop_ctrl.sv
// Per-channel tracking-loop sequencer: epoch timer, strobe generation, overrun counting
// and the IDLE/WARM/PULLIN/TRACK/LOST state machine driving loop-filter bandwidth.
module trk_loop_ctrl
    import trk_pkg::*;
#(
    parameter int               DISC_LAT = 19,
    parameter int               LOCK_CNT = 8,
    parameter int               LOSS_CNT = 16,
    parameter logic [ACC_W-1:0] PWR_TH   = 24'd4096,
    parameter int               CNT_W    = 8
) (
    input  logic             rx_clk,
    input  logic             rx_rst_n,
    input  logic             rx_en,
    input  logic             rx_prn_sop,
    input  logic [ACC_W-1:0] rx_acc_P_real,
    input  logic [ACC_W-1:0] rx_acc_P_imag,
    output logic             tx_disc_latch,
    output logic             tx_lpf_upd,
    output logic             tx_lpf_clr,
    output logic [1:0]       tx_bw_sel,
    output logic             tx_lock,
    output logic             tx_lost,
    output logic [2:0]       tx_state,
    output logic [CNT_W-1:0] tx_ovr_cnt
);

    localparam int TMR_W = $clog2(DISC_LAT + 2);

    trk_state_e       state_q, state_d;
    logic             run_q,   run_d;
    logic [TMR_W-1:0] tmr_q,   tmr_d;
    logic             eval_q,  eval_d;
    logic [CNT_W-1:0] ovr_q,   ovr_d;

    logic active;
    logic disc_due;
    logic upd_due;
    logic overrun;
    logic lock_hit;
    logic loss_hit;
    logic cnt_clr;
    logic lpf_clr;
    logic lost_pulse;

    assign active   = (state_q == TRK_PULLIN) || (state_q == TRK_TRACK) || (state_q == TRK_LOST);
    assign disc_due = run_q && (tmr_q == TMR_W'(DISC_LAT));
    assign upd_due  = run_q && (tmr_q == TMR_W'(DISC_LAT + 1));
    assign overrun  = rx_en && active && rx_prn_sop && run_q && !upd_due;

    // tmr_q holds cycles elapsed since the sop (sop cycle = 0); a new sop always restarts it.
    always_comb begin
        run_d  = run_q;
        tmr_d  = tmr_q;
        eval_d = rx_en && active && rx_prn_sop;
        if (!rx_en || !active) begin
            run_d = 1'b0;
            tmr_d = '0;
        end else if (rx_prn_sop) begin
            run_d = 1'b1;
            tmr_d = TMR_W'(1);
        end else if (upd_due) begin
            run_d = 1'b0;
        end else if (run_q) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_comb begin
        ovr_d = ovr_q;
        if (!rx_en) begin
            ovr_d = '0;
        end else if (overrun && (ovr_q != {CNT_W{1'b1}})) begin
            ovr_d = ovr_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        lpf_clr    = 1'b0;
        lost_pulse = 1'b0;
        if (!rx_en) begin
            state_d = TRK_IDLE;
        end else begin
            case (state_q)
                TRK_IDLE: state_d = TRK_WARM;
                TRK_WARM: begin
                    if (rx_prn_sop) begin
                        state_d = TRK_PULLIN;
                        lpf_clr = 1'b1;
                    end
                end
                TRK_PULLIN, TRK_LOST: begin
                    if (lock_hit) state_d = TRK_TRACK;
                end
                TRK_TRACK: begin
                    if (loss_hit) begin
                        state_d    = TRK_LOST;
                        lost_pulse = 1'b1;
                        lpf_clr    = 1'b1;
                    end
                end
                default: state_d = TRK_IDLE;
            endcase
        end
        cnt_clr = (state_d != state_q);
    end

    trk_lock_det #(
        .PWR_TH   (PWR_TH),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) u_lock_det (
        .clk      (rx_clk),
        .rst_n    (rx_rst_n),
        .en       (rx_en),
        .eval     (eval_q),
        .clr      (cnt_clr),
        .acc_i    (rx_acc_P_real),
        .acc_q    (rx_acc_P_imag),
        .lock_hit (lock_hit),
        .loss_hit (loss_hit)
    );

    // The update strobe follows the state being entered, so LOST entry suppresses it at once.
    always_comb begin
        tx_disc_latch = rx_en && disc_due;
        tx_lpf_upd    = rx_en && upd_due && ((state_d == TRK_PULLIN) || (state_d == TRK_TRACK));
        tx_lpf_clr    = lpf_clr;
        tx_lost       = lost_pulse;
        tx_lock       = (state_q == TRK_TRACK);
        tx_state      = state_q;
        tx_ovr_cnt    = ovr_q;
        case (state_q)
            TRK_PULLIN, TRK_LOST: tx_bw_sel = BW_WIDE;
            TRK_TRACK:            tx_bw_sel = BW_NARROW;
            default:              tx_bw_sel = BW_IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q <= TRK_IDLE;
            run_q   <= 1'b0;
            tmr_q   <= '0;
            eval_q  <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            tmr_q   <= tmr_d;
            eval_q  <= eval_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_trk_loop_ctrl.sv
// Self-checking bench for trk_loop_ctrl: strobe cycles are scoreboarded per epoch,
// state/bandwidth/counter values are checked at scenario boundaries.
module tb_trk_loop_ctrl;
    import trk_pkg::*;

    localparam int DISC_LAT = 19;

    logic        rx_clk = 1'b0;
    logic        rx_rst_n = 1'b0;
    logic        rx_en = 1'b0;
    logic        rx_prn_sop = 1'b0;
    logic [23:0] rx_acc_P_real = '0;
    logic [23:0] rx_acc_P_imag = '0;
    logic        tx_disc_latch;
    logic        tx_lpf_upd;
    logic        tx_lpf_clr;
    logic [1:0]  tx_bw_sel;
    logic        tx_lock;
    logic        tx_lost;
    logic [2:0]  tx_state;
    logic [7:0]  tx_ovr_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    int disc_q[$];
    int upd_q[$];
    int clr_q[$];
    int lost_q[$];

    trk_loop_ctrl #(.DISC_LAT(DISC_LAT)) dut (
        .rx_clk        (rx_clk),
        .rx_rst_n      (rx_rst_n),
        .rx_en         (rx_en),
        .rx_prn_sop    (rx_prn_sop),
        .rx_acc_P_real (rx_acc_P_real),
        .rx_acc_P_imag (rx_acc_P_imag),
        .tx_disc_latch (tx_disc_latch),
        .tx_lpf_upd    (tx_lpf_upd),
        .tx_lpf_clr    (tx_lpf_clr),
        .tx_bw_sel     (tx_bw_sel),
        .tx_lock       (tx_lock),
        .tx_lost       (tx_lost),
        .tx_state      (tx_state),
        .tx_ovr_cnt    (tx_ovr_cnt)
    );

    always #5 rx_clk = ~rx_clk;
    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard side: every strobe seen must be the next one expected, at the expected cycle.
    initial begin
        forever begin
            @(negedge rx_clk);
            if (tx_disc_latch) begin
                if (disc_q.size() == 0) check("disc_unexpected", cyc, -1);
                else                    check("disc_cycle", cyc, disc_q.pop_front());
            end
            if (tx_lpf_upd) begin
                if (upd_q.size() == 0) check("upd_unexpected", cyc, -1);
                else                   check("upd_cycle", cyc, upd_q.pop_front());
            end
            if (tx_lpf_clr) begin
                if (clr_q.size() == 0) check("clr_unexpected", cyc, -1);
                else                   check("clr_cycle", cyc, clr_q.pop_front());
            end
            if (tx_lost) begin
                if (lost_q.size() == 0) check("lost_unexpected", cyc, -1);
                else                    check("lost_cycle", cyc, lost_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    // One epoch: sop now, accumulators valid from the next cycle; expected strobes queued up front.
    task automatic epoch(input int i_val, input int q_val, input bit exp_disc, input bit exp_upd,
                         input int clr_off, input bit exp_lost, input int period);
        int t;
        t = cyc;
        rx_prn_sop = 1'b1;
        if (exp_disc)     disc_q.push_back(t + DISC_LAT);
        if (exp_upd)      upd_q.push_back(t + DISC_LAT + 1);
        if (clr_off >= 0) clr_q.push_back(t + clr_off);
        if (exp_lost)     lost_q.push_back(t + 1);
        tick(1);
        rx_prn_sop    = 1'b0;
        rx_acc_P_real = 24'(i_val);
        rx_acc_P_imag = 24'(q_val);
        tick(period - 1);
    endtask

    task automatic sop_only();
        rx_prn_sop = 1'b1;
        tick(1);
        rx_prn_sop = 1'b0;
    endtask

    int lock_i[13] = '{100000, 100000, 100000, 100000, 3000, 4096, 8192, 100000, -200000,
                       100000, 100000, 100000, 100000};
    int lock_q[13] = '{10000, 10000, 10000, 10000, 0, 0, 4096, -50000, 100000,
                       10000, 10000, 10000, 10000};

    initial begin
        tick(3);
        check("rst_state", tx_state, TRK_IDLE);
        check("rst_bw", tx_bw_sel, BW_IDLE);
        check("rst_lock", tx_lock, 0);
        check("rst_ovr", tx_ovr_cnt, 0);
        check("rst_strobes", {tx_disc_latch, tx_lpf_upd, tx_lpf_clr, tx_lost}, 0);
        rx_rst_n = 1'b1;
        tick(2);
        check("en0_idle", tx_state, TRK_IDLE);
        rx_en = 1'b1;
        tick(2);
        check("warm_state", tx_state, TRK_WARM);
        check("warm_bw", tx_bw_sel, BW_IDLE);

        // Partial first epoch: clear strobe on the sop, no disc/upd.
        epoch(0, 0, 0, 0, 0, 0, 2000);
        check("pullin_state", tx_state, TRK_PULLIN);
        check("pullin_bw", tx_bw_sel, BW_WIDE);
        repeat (2) epoch(3000, 0, 1, 1, -1, 0, 2000);

        // Acquisition with one weak epoch, good epochs including the >= boundaries.
        for (int i = 0; i < 13; i++) begin
            epoch(lock_i[i], lock_q[i], 1, 1, -1, 0, 40);
            if (i == 11) check("lock_not_yet", tx_lock, 0);
        end
        check("lock_up", tx_lock, 1);
        check("track_bw", tx_bw_sel, BW_NARROW);
        check("track_state", tx_state, TRK_TRACK);

        // Loss: 16 bad epochs, the last one enters LOST and drops its update strobe.
        for (int i = 0; i < 16; i++) begin
            epoch(1000, 50000, 1, (i < 15), (i == 15) ? 1 : -1, (i == 15), 40);
            if (i == 14) check("track_hold", tx_state, TRK_TRACK);
        end
        check("lost_state", tx_state, TRK_LOST);
        check("lost_bw", tx_bw_sel, BW_WIDE);
        check("lost_lock", tx_lock, 0);

        // Re-acquire from LOST: only the epoch that returns to TRACK produces an update.
        for (int i = 0; i < 8; i++) begin
            epoch(100000, 10000, 1, (i == 7), -1, 0, 40);
            if (i == 6) check("lost_hold", tx_state, TRK_LOST);
        end
        check("relock_state", tx_state, TRK_TRACK);

        // Single overrun: sop at t and t+10, strobes only at t+29/t+30.
        epoch(100000, 10000, 0, 0, -1, 0, 10);
        epoch(100000, 10000, 1, 1, -1, 0, 40);
        check("ovr_one", tx_ovr_cnt, 1);
        check("ovr_track", tx_state, TRK_TRACK);

        // Asynchronous reset mid-epoch.
        sop_only();
        tick(5);
        rx_rst_n = 1'b0;
        #1;
        check("arst_state", tx_state, TRK_IDLE);
        check("arst_lock", tx_lock, 0);
        check("arst_bw", tx_bw_sel, BW_IDLE);
        check("arst_ovr", tx_ovr_cnt, 0);
        check("arst_strobes", {tx_disc_latch, tx_lpf_upd, tx_lpf_clr, tx_lost}, 0);
        tick(3);
        rx_rst_n = 1'b1;
        tick(25);
        check("arst_warm", tx_state, TRK_WARM);

        // Overrun saturation: 300 sops 10 cycles apart, only the last epoch completes.
        epoch(0, 0, 0, 0, 0, 0, 40);
        for (int i = 0; i < 300; i++) begin
            epoch(0, 0, (i == 299), (i == 299), -1, 0, (i == 299) ? 40 : 10);
            if (i == 100) check("ovr_mid", tx_ovr_cnt, 100);
        end
        check("ovr_sat", tx_ovr_cnt, 255);
        check("ovr_pullin", tx_state, TRK_PULLIN);

        // Enable drop mid-epoch: pending strobes cancelled, no lost pulse.
        sop_only();
        tick(5);
        rx_en = 1'b0;
        tick(30);
        check("endrop_state", tx_state, TRK_IDLE);
        check("endrop_ovr", tx_ovr_cnt, 0);
        check("endrop_bw", tx_bw_sel, BW_IDLE);
        rx_en = 1'b1;
        tick(2);
        check("reen_warm", tx_state, TRK_WARM);

        // Most negative I saturates to 2^23-1 and counts as good.
        epoch(0, 0, 0, 0, 0, 0, 40);
        for (int i = 0; i < 8; i++) begin
            epoch(-8388608, 0, 1, 1, -1, 0, 40);
            if (i == 6) check("edge_not_yet", tx_lock, 0);
        end
        check("edge_lock", tx_lock, 1);
        check("edge_state", tx_state, TRK_TRACK);

        tick(5);
        check("disc_pending", disc_q.size(), 0);
        check("upd_pending", upd_q.size(), 0);
        check("clr_pending", clr_q.size(), 0);
        check("lost_pending", lost_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/trk_loop_ctrl.md
Name: trk_loop_ctrl

Overview:
Per-channel tracking-loop sequencer for the B1 correlator/discriminator/loop-filter chain. It times each integration epoch from the PRN start-of-period strobe and generates the discriminator-capture and loop-filter-update strobes. It runs a lock detector on the prompt accumulators and moves the channel through warm-up, pull-in, track and lost states. Its outputs select loop-filter bandwidth and clear filter state.

Parameters:
DISC_LAT, 19, cycles from rx_prn_sop to discriminator outputs valid (CORDIC divide/atan latency)
LOCK_CNT, 8, consecutive good epochs required for PULLIN→TRACK
LOSS_CNT, 16, consecutive bad epochs required for TRACK→LOST
PWR_TH, 24'd4096, minimum |I| for a good epoch
CNT_W, 8, width of epoch/overrun counters

Ports:
rx_clk  in  1  system clock
rx_rst_n  in  1  asynchronous active-low reset
rx_en  in  1  channel enable; low forces IDLE
rx_prn_sop  in  1  epoch boundary strobe, 1 cycle
rx_acc_P_real  in  24  prompt I accumulator, signed, valid from cycle after sop
rx_acc_P_imag  in  24  prompt Q accumulator, signed, valid from cycle after sop
tx_disc_latch  out  1  1-cycle strobe: capture DLL/PLL discriminator outputs
tx_lpf_upd  out  1  1-cycle strobe: loop filter update
tx_lpf_clr  out  1  1-cycle strobe: clear loop filter integrators
tx_bw_sel  out  2  00 idle, 01 wide (pull-in), 10 narrow (track)
tx_lock  out  1  high while in TRACK
tx_lost  out  1  1-cycle pulse on entry to LOST
tx_state  out  3  encoded state for debug
tx_ovr_cnt  out  CNT_W  saturating count of epoch overruns

Behaviour:
- Reset, and whenever rx_en=0: state IDLE. All strobes 0, tx_bw_sel=00, tx_lock=0, tx_state=IDLE, epoch timer idle, good/bad counters 0, tx_ovr_cnt=0. Reset is asserted asynchronously and released synchronously to rx_clk.
- States: IDLE=0, WARM=1, PULLIN=2, TRACK=3, LOST=4.
- IDLE→WARM on rx_en=1.
- WARM: the first epoch is partial. On the first rx_prn_sop, move to PULLIN and pulse tx_lpf_clr in the same cycle. Generate no disc/upd strobes for this epoch.
- Epoch timer, active in PULLIN/TRACK/LOST:
  - rx_prn_sop at cycle t loads the timer with 0.
  - tx_disc_latch fires at t+DISC_LAT.
  - tx_lpf_upd fires at t+DISC_LAT+1.
  - The timer then idles until the next sop.
- Overrun: rx_prn_sop arriving while the timer is running and before tx_lpf_upd has fired:
  - tx_ovr_cnt increments, saturating at all-ones.
  - Pending strobes of the old epoch are dropped.
  - The timer restarts for the new epoch.
- Lock metric is evaluated once per epoch at t+1, where t is the sop cycle:
  - aI=|rx_acc_P_real| and aQ=|rx_acc_P_imag|, both 24-bit. Absolute value of -2^23 saturates to 2^23-1.
  - good = (aI >= PWR_TH) && (aI >= 2*aQ), with the comparison done at 25 bits.
- PULLIN: tx_bw_sel=01.
  - good increments good_cnt; bad clears it.
  - When good_cnt reaches LOCK_CNT: go to TRACK and clear bad_cnt.
- TRACK: tx_bw_sel=10, tx_lock=1.
  - bad increments bad_cnt; good clears it.
  - When bad_cnt reaches LOSS_CNT: go to LOST, pulse tx_lost, pulse tx_lpf_clr.
- LOST: tx_bw_sel=01, tx_lpf_upd suppressed (tx_disc_latch still fires).
  - Counts good epochs as in PULLIN.
  - After LOCK_CNT consecutive good epochs, go to TRACK.
- If a state change and tx_lpf_upd fall in the same cycle, the strobe uses the new state's rules.
- Counters saturate at their thresholds. No wrap-around.
- rx_en deassert mid-epoch: immediate IDLE, pending strobes cancelled, no tx_lost.
- Asynchronous reset mid-epoch: same as rx_en deassert, plus tx_ovr_cnt is cleared.

Decomposition:
- Shared package trk_pkg holds:
  - state encoding constants (TRK_IDLE..TRK_LOST);
  - bandwidth codes BW_IDLE/BW_WIDE/BW_NARROW;
  - the accumulator width constant ACC_W=24.
- One sub-module, trk_lock_det: combinational absolute value and comparison producing `good`, plus the registered good/bad counters. The top level holds the FSM and the epoch timer.

Test Plan:
- Reset/enable: assert rx_rst_n=0 mid-epoch → all outputs 0 immediately. Release, set rx_en=1 → state WARM. First sop → tx_lpf_clr pulse, state PULLIN, no tx_disc_latch for that epoch.
- Timing: sop every 2000 cycles with DISC_LAT=19 → tx_disc_latch exactly at sop+19 and tx_lpf_upd at sop+20, each one cycle wide.
- Lock acquisition: I=100000, Q=10000 for 8 epochs → tx_lock rises after the 8th evaluation and tx_bw_sel goes 01→10. I=3000 (<PWR_TH) at the 5th epoch → good_cnt resets and lock arrives 5 epochs later.
- Loss: in TRACK, drive I=1000, Q=50000 for 16 epochs → tx_lost single pulse, tx_lpf_clr pulse, state LOST, tx_lpf_upd absent while tx_disc_latch is still present. 8 good epochs → TRACK again.
- Overrun: sop at t and again at t+10 → tx_ovr_cnt=1 and the only strobes are at t+29 and t+30. Repeat 300 times → tx_ovr_cnt holds at 255.
- Edge value: I=-8388608, Q=0 → treated as aI=8388607, epoch counted good.
